// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline stage with a skid buffer. It stalls on one bit of a shared
// stall vector and flushes all held entries on request.
module pipe_skid_reg #(
   parameter int DATA_W    = 75,
   parameter int STALL_W   = 6,
   parameter int STALL_BIT = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall_i,
   input  logic               flush_i,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   input  logic               out_ready,
   output logic [1:0]         occupancy
);

   // Encoding doubles as the held-entry count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t              r_state, w_state_nx;
   logic [DATA_W-1:0]   r_main, r_skid, w_main_nx, w_skid_nx;
   logic                w_stall, w_accept, w_consume;
   logic                w_unused_stall;

   assign w_stall        = stall_i[STALL_BIT];
   assign w_unused_stall = ^stall_i;

   assign in_ready  = rst & (r_state != ST_SKID) & ~w_stall & ~flush_i;
   assign out_valid = (r_state != ST_EMPTY);
   assign out_data  = out_valid ? r_main : '0;
   assign occupancy = r_state;

   assign w_accept  = in_valid & in_ready;
   assign w_consume = out_valid & out_ready & ~w_stall;

   // Stall needs no branch of its own: it already gates accept and consume.
   always_comb begin
      w_state_nx = r_state;
      w_main_nx  = r_main;
      w_skid_nx  = r_skid;
      if (flush_i) begin
         w_state_nx = ST_EMPTY;
         w_main_nx  = '0;
         w_skid_nx  = '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nx = ST_FULL;
                  w_main_nx  = in_data;
               end
            end
            ST_FULL: begin
               if (w_accept && !w_consume) begin
                  w_state_nx = ST_SKID;
                  w_skid_nx  = in_data;
               end else if (w_consume && !w_accept) begin
                  w_state_nx = ST_EMPTY;
               end else if (w_accept && w_consume) begin
                  w_main_nx  = in_data;
               end
            end
            ST_SKID: begin
               if (w_consume) begin
                  w_state_nx = ST_FULL;
                  w_main_nx  = r_skid;
               end
            end
            default: begin
               w_state_nx = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_main  <= w_main_nx;
         r_skid  <= w_skid_nx;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table against the default-parameter stage, then a FIFO-model
// check of an 8-bit instance that stalls on bit 1.
module tb_pipe_skid_reg;

   localparam int DW = 75;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [5:0]    stall_i;
   logic          flush_i, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic [1:0]    occupancy;

   logic [5:0]    s8_stall;
   logic          s8_flush, s8_iv, s8_ir, s8_ov, s8_or;
   logic [7:0]    s8_id, s8_od;
   logic [1:0]    s8_occ;

   pipe_skid_reg u_dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .occupancy(occupancy)
   );

   pipe_skid_reg #(.DATA_W(8), .STALL_W(6), .STALL_BIT(1)) u_dut8 (
      .clk(clk), .rst(rst), .stall_i(s8_stall), .flush_i(s8_flush),
      .in_valid(s8_iv), .in_data(s8_id), .in_ready(s8_ir),
      .out_valid(s8_ov), .out_data(s8_od), .out_ready(s8_or),
      .occupancy(s8_occ)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic          rst;
      logic [5:0]    stall;
      logic          flush;
      logic          iv;
      logic [DW-1:0] d;
      logic          ordy;
      logic          e_ir;
      logic          e_ov;
      logic [DW-1:0] e_od;
      logic [1:0]    e_occ;
   } vec_t;

   vec_t vecs[$];

   // e_ir is checked before the edge; e_ov/e_od/e_occ just after it.
   function automatic vec_t mk(input logic r, input logic [5:0] st, input logic fl,
                               input logic iv, input int d, input logic ordy,
                               input logic e_ir, input logic e_ov, input int e_od,
                               input int e_occ);
      vec_t v;
      v.rst = r; v.stall = st; v.flush = fl; v.iv = iv; v.d = DW'(d); v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = DW'(e_od); v.e_occ = 2'(e_occ);
      return v;
   endfunction

   logic [7:0] q[$];

   task automatic step8(input logic [5:0] st, input logic fl, input logic iv,
                        input logic [7:0] d, input logic ordy, input string tag);
      logic e_ir, acc, cons;
      s8_stall = st; s8_flush = fl; s8_iv = iv; s8_id = d; s8_or = ordy;
      #1;
      e_ir = (q.size() < 2) && !st[1] && !fl;
      chk({tag, ".in_ready"},  DW'(s8_ir),  DW'(e_ir));
      chk({tag, ".out_valid"}, DW'(s8_ov),  DW'(q.size() > 0));
      chk({tag, ".out_data"},  DW'(s8_od),  (q.size() > 0) ? DW'(q[0]) : '0);
      chk({tag, ".occupancy"}, DW'(s8_occ), DW'(q.size()));
      acc  = iv && e_ir;
      cons = (q.size() > 0) && ordy && !st[1];
      @(posedge clk);
      #1;
      if (fl) begin
         q.delete();
      end else begin
         if (cons) void'(q.pop_front());
         if (acc) q.push_back(d);
      end
   endtask

   initial begin
      rst = 1'b0; stall_i = '0; flush_i = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      s8_stall = '0; s8_flush = 1'b0; s8_iv = 1'b0; s8_id = '0; s8_or = 1'b0;

      // Reset, including a reset cycle that offers data.
      vecs.push_back(mk(0, 6'h00, 0, 0, 0,    0, 0, 0, 0,    0));
      vecs.push_back(mk(0, 6'h08, 1, 1, 5,    1, 0, 0, 0,    0));
      // Stream 1,2,3 with out_ready high.
      vecs.push_back(mk(1, 6'h00, 0, 1, 1,    1, 1, 1, 1,    1));
      vecs.push_back(mk(1, 6'h00, 0, 1, 2,    1, 1, 1, 2,    1));
      vecs.push_back(mk(1, 6'h00, 0, 1, 3,    1, 1, 1, 3,    1));
      vecs.push_back(mk(1, 6'h00, 0, 0, 0,    1, 1, 0, 0,    0));
      // Skid fill and drain; the offer of 0xE while in SKID is not taken.
      vecs.push_back(mk(1, 6'h00, 0, 1, 'hA,  0, 1, 1, 'hA,  1));
      vecs.push_back(mk(1, 6'h00, 0, 1, 'hB,  0, 1, 1, 'hA,  2));
      vecs.push_back(mk(1, 6'h00, 0, 1, 'hE,  0, 0, 1, 'hA,  2));
      vecs.push_back(mk(1, 6'h00, 0, 0, 0,    1, 0, 1, 'hB,  1));
      vecs.push_back(mk(1, 6'h00, 0, 0, 0,    1, 1, 0, 0,    0));
      // Stall on bit 3 freezes FULL; a different bit does not.
      vecs.push_back(mk(1, 6'h00, 0, 1, 'hC,  0, 1, 1, 'hC,  1));
      vecs.push_back(mk(1, 6'h08, 0, 1, 'h11, 1, 0, 1, 'hC,  1));
      vecs.push_back(mk(1, 6'h08, 0, 1, 'h12, 1, 0, 1, 'hC,  1));
      vecs.push_back(mk(1, 6'h08, 0, 1, 'h13, 1, 0, 1, 'hC,  1));
      vecs.push_back(mk(1, 6'h04, 0, 0, 0,    1, 1, 0, 0,    0));
      // Flush in SKID overrides stall and the offered 0xD.
      vecs.push_back(mk(1, 6'h00, 0, 1, 'hA,  0, 1, 1, 'hA,  1));
      vecs.push_back(mk(1, 6'h00, 0, 1, 'hB,  0, 1, 1, 'hA,  2));
      vecs.push_back(mk(1, 6'h08, 1, 1, 'hD,  1, 0, 0, 0,    0));
      vecs.push_back(mk(1, 6'h00, 0, 0, 0,    1, 1, 0, 0,    0));
      // Stall holds SKID, then reset drops both entries.
      vecs.push_back(mk(1, 6'h00, 0, 1, 'hA,  0, 1, 1, 'hA,  1));
      vecs.push_back(mk(1, 6'h00, 0, 1, 'hB,  0, 1, 1, 'hA,  2));
      vecs.push_back(mk(1, 6'h08, 0, 0, 0,    1, 0, 1, 'hA,  2));
      vecs.push_back(mk(0, 6'h00, 0, 1, 7,    1, 0, 0, 0,    0));
      vecs.push_back(mk(1, 6'h00, 0, 0, 0,    0, 1, 0, 0,    0));
      // Accept plus flush in FULL: the input is dropped, not stored.
      vecs.push_back(mk(1, 6'h00, 0, 1, 'h21, 0, 1, 1, 'h21, 1));
      vecs.push_back(mk(1, 6'h00, 1, 1, 'h22, 0, 0, 0, 0,    0));
      vecs.push_back(mk(1, 6'h00, 0, 0, 0,    0, 1, 0, 0,    0));

      foreach (vecs[i]) begin
         rst = vecs[i].rst; stall_i = vecs[i].stall; flush_i = vecs[i].flush;
         in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
         #1;
         chk($sformatf("v%0d.in_ready", i), DW'(in_ready), DW'(vecs[i].e_ir));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d.out_valid", i), DW'(out_valid), DW'(vecs[i].e_ov));
         chk($sformatf("v%0d.out_data", i),  out_data,       vecs[i].e_od);
         chk($sformatf("v%0d.occupancy", i), DW'(occupancy), DW'(vecs[i].e_occ));
      end
      in_valid = 1'b0; out_ready = 1'b0; stall_i = '0; flush_i = 1'b0;

      // 8-bit instance: bit 1 freezes, bit 3 is ignored.
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      step8(6'b000000, 0, 1, 8'h55, 0, "s8.fill");
      step8(6'b000010, 0, 1, 8'h66, 1, "s8.frz");
      chk("s8.frz_occ",  DW'(s8_occ), DW'(1));
      chk("s8.frz_data", DW'(s8_od),  DW'(8'h55));
      step8(6'b001000, 0, 0, 8'h00, 1, "s8.nofrz");
      step8(6'b000000, 0, 0, 8'h00, 0, "s8.idle");
      chk("s8.drained", DW'(s8_occ), DW'(0));

      for (int c = 0; c < 10000; c++) begin
         logic [5:0] st;
         st = 6'($urandom_range(0, 63)) & 6'b111101;
         if ($urandom_range(0, 4) == 0) st[1] = 1'b1;
         step8(st, ($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7),
               8'($urandom_range(0, 255)), ($urandom_range(0, 9) < 6), "s8.rnd");
      end
      step8(6'b000000, 0, 0, 8'h00, 1, "s8.end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 75, payload width in bits (rd_data 32 + rd_addr 5 + rd_enable 1 + load/store enables 2 + mem_addr 32 + ls_type 3 packed by instantiator).
REQ-002 Parameter STALL_W, default 6, width of stall vector from stall_ctrl.
REQ-003 Parameter STALL_BIT, default 3, index of stall_i bit that freezes this stage; 0 <= STALL_BIT < STALL_W.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-006 stall_i  input  STALL_W  stall vector; bit STALL_BIT = 1 freezes stage.
REQ-007 flush_i  input  1  discard all held entries (branch mispredict / exception).
REQ-008 in_valid  input  1  upstream payload valid.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_ready  output  1  stage can accept payload this cycle.
REQ-011 out_valid  output  1  downstream payload valid.
REQ-012 out_data  output  DATA_W  downstream payload.
REQ-013 out_ready  input  1  downstream consumes payload this cycle.
REQ-014 occupancy  output  2  number of held entries, 0..2.

Function
REQ-015 Storage SHALL be two entries: main (drives out_data) and skid; states EMPTY (0 held), FULL (main only), SKID (main+skid).
REQ-016 stall = stall_i[STALL_BIT]; accept = in_valid & in_ready; consume = out_valid & out_ready & ~stall.
REQ-017 in_ready SHALL be combinational: 1 iff rst = 1, state != SKID, stall = 0, flush_i = 0.
REQ-018 out_valid SHALL be 1 iff state != EMPTY; out_data SHALL equal main entry when out_valid = 1, all-zero (bubble) otherwise.
REQ-019 EMPTY: accept -> FULL, main <= in_data; else stay.
REQ-020 FULL: accept & ~consume -> SKID, skid <= in_data; consume & ~accept -> EMPTY; accept & consume -> FULL, main <= in_data; neither -> stay, main unchanged.
REQ-021 SKID: consume -> FULL, main <= skid; else stay, both entries unchanged (in_ready = 0 so no accept).
REQ-022 Latency: payload accepted at edge N SHALL appear on out_data with out_valid = 1 after edge N (one cycle) when stage was EMPTY or consumed simultaneously.
REQ-023 Ordering SHALL be strict FIFO; no payload duplicated or dropped except by flush or reset.
REQ-024 stall = 1 SHALL hold state, main and skid unchanged regardless of in_valid/out_ready; out_valid/out_data keep presenting held main.
REQ-025 flush_i = 1 SHALL, at next edge, force state EMPTY and zero both entries; overrides stall, accept and consume in same cycle (input that cycle dropped).
REQ-026 occupancy SHALL equal 0/1/2 for EMPTY/FULL/SKID, registered with state.
REQ-027 Full throughput: with out_ready = 1, stall = 0, in_valid = 1 continuously, stage SHALL pass one payload per cycle with state FULL.

Reset
REQ-028 When rst = 0 at a rising edge: state EMPTY, main and skid all-zero, occupancy 0, out_valid 0, out_data 0.
REQ-029 While rst = 0, in_ready SHALL be 0; reset SHALL override flush, stall and handshake; entries held mid-operation are lost.
REQ-030 First accept possible at first rising edge with rst = 1.

Verification
REQ-031 Reset then stream 0x1,0x2,0x3 with out_ready = 1 -> out_data 0x1,0x2,0x3 on consecutive cycles, one-cycle latency, occupancy 1.
REQ-032 FULL holding 0xA, out_ready = 0, in 0xB -> SKID, in_ready 0, occupancy 2; out_ready = 1 two cycles -> 0xA then 0xB, then EMPTY.
REQ-033 FULL with 0xC, stall_i = 6'b001000, in_valid = 1, out_ready = 1 for 3 cycles -> in_ready 0, out_data stays 0xC, occupancy 1; release -> 0xC consumed.
REQ-034 SKID (0xA,0xB), flush_i = 1 with in_valid = 1, in_data 0xD, stall = 1 -> next cycle EMPTY, out_valid 0, out_data 0, 0xD never output.
REQ-035 SKID state, rst = 0 one cycle -> occupancy 0, out_valid 0, in_ready 0 during reset, in_ready 1 cycle after release.
REQ-036 DATA_W = 8, STALL_BIT = 1: stall_i = 6'b000010 freezes, stall_i = 6'b001000 does not; random valid/ready 10k cycles vs FIFO model -> no loss, no reorder.
